// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, nibble width and the
// sequencing state enum used by the nibble-serial adder controller.
package alu_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam int         NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl.sv
// Feeds a wide add through an external 4-bit adder one nibble per cycle, LSB first.
// Define NSA_SUB_EN to add the in_sub port (subtract via ~B + 1).
module nibble_serial_adder_ctrl
    import alu_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic                in_cin,
`ifdef NSA_SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_sum,
    output logic                out_cout,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    output logic [2:0]          add_control,
    input  logic [NIBBLE_W-1:0] add_result,
    input  logic                add_cout
);

    localparam int              IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nsa_state_e                       state_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [IDX_W-1:0]                 idx_d;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] sum_q;
    logic                             carry_q;
    logic                             out_valid_q;

    assign idx_d = idx_q + 1'b1;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
`ifdef NSA_SUB_EN
                        // Two's-complement subtract: invert B and force carry-in high.
                        if (in_sub) begin
                            b_q     <= ~in_b;
                            carry_q <= 1'b1;
                        end
`endif
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= add_result;
                    carry_q      <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_sum     = sum_q;
    assign out_cout    = carry_q;
    assign add_control = ALU_OP_ADD;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder
// and an arithmetic reference model; NSA_SUB_EN enables the subtract cases.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [2:0]   add_control;
    logic [3:0]   add_result;
    logic         add_cout;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
`ifdef NSA_SUB_EN
        .in_sub     (in_sub),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_control(add_control),
        .add_result (add_result),
        .add_cout   (add_cout)
    );

    // The external 4-bit adder stage.
    assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        r;
        longint      full;
        if (sub) begin
            r.sum  = W'(a - b);
            r.cout = (a >= b);
        end else begin
            full   = longint'(a) + longint'(b) + longint'(cin);
            r.sum  = full[W-1:0];
            r.cout = full[W];
        end
        r.acc = 0;
        return r;
    endfunction

    // Drive a request from posedge+1 until accepted; returns at accept edge + 1.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, output int acc);
        exp_t e;
        int   waited;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                acc      = -1;
                @(posedge clk);
                #1;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc   = cyc;
        e     = model(a, b, cin, sub);
        e.acc = acc;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    // Returns at the first negedge showing out_valid, or flags a timeout.
    task automatic wait_valid();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) return;
        end
        check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: latency, hold-under-backpressure, scoreboard pop, opcode.
    logic         mon_en     = 1'b0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [W-1:0] prev_sum   = '0;
    logic         prev_cout  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", 32'(out_sum), 32'(prev_sum));
                check("hold_cout", 32'(out_cout), 32'(prev_cout));
            end
            if (out_valid === 1'b1 && prev_valid !== 1'b1 && sb.size() > 0)
                check("latency", 32'(cyc - sb[0].acc), 32'(NIBBLES));
            if (out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    check("out_without_request", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_sum", 32'(out_sum), 32'(e.sum));
                    check("sb_cout", 32'(out_cout), 32'(e.cout));
                end
            end
            check("add_control", 32'(add_control), 32'h2);
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_sum   = out_sum;
            prev_cout  = out_cout;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_a;
        int          acc_b;
        int          t0;
        logic [W-1:0] hs;
        logic        hc;
        logic [3:0]  cin_seq;
        logic        rnd_done;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'd0);
        check("reset_out_cout", 32'(out_cout), 32'd0);
        check("reset_add_a", 32'(add_a), 32'd0);
        check("reset_add_b", 32'(add_b), 32'd0);
        check("reset_add_cin", 32'(add_cin), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with per-nibble carries.
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, acc_a);
        wait_valid();
        check("t1_sum", 32'(out_sum), 32'h2233);
        check("t1_cout", 32'(out_cout), 32'd0);
        @(posedge clk);
        #1;

        // Full carry ripple; watch the carry fed to each nibble.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc_a);
        cin_seq = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_add_cin", 32'(add_cin), 32'(cin_seq[i]));
        end
        wait_valid();
        check("t2_sum", 32'(out_sum), 32'h0000);
        check("t2_cout", 32'(out_cout), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: result holds, a pending request is not taken.
        out_ready = 1'b0;
        send(16'hA5A5, 16'h1111, 1'b1, 1'b0, acc_a);
        wait_valid();
        hs = out_sum;
        hc = out_cout;
        @(posedge clk);
        #1;
        in_a     = 16'h0101;
        in_b     = 16'h0202;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(out_sum), 32'(hs));
            check("bp_cout", 32'(out_cout), 32'(hc));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        t0 = cyc;
        send(16'h0101, 16'h0202, 1'b0, 1'b0, acc_b);
        check("bp_accept_edge", 32'(acc_b - t0), 32'd2);
        wait_valid();
        @(posedge clk);
        #1;

        // Reset two RUN cycles into an operation.
        send(16'h4321, 16'h1234, 1'b1, 1'b0, acc_a);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrun_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrun_no_valid", 32'(out_valid), 32'd0);
            check("midrun_sum_clear", 32'(out_sum), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0004, 1'b0, 1'b0, acc_a);
        wait_valid();
        check("post_reset_sum", 32'(out_sum), 32'h0007);
        @(posedge clk);
        #1;

        // Back-to-back requests with a ready consumer.
        send(16'h8000, 16'h8000, 1'b0, 1'b0, acc_a);
        send(16'h7FFF, 16'h0001, 1'b1, 1'b0, acc_b);
        check("b2b_spacing", 32'(acc_b - acc_a), 32'(NIBBLES + 2));
        wait_valid();
        @(posedge clk);
        #1;

`ifdef NSA_SUB_EN
        send(16'h0005, 16'h0007, 1'b1, 1'b1, acc_a);
        wait_valid();
        check("sub_neg_sum", 32'(out_sum), 32'hFFFE);
        check("sub_neg_cout", 32'(out_cout), 32'd0);
        @(posedge clk);
        #1;
        send(16'h0007, 16'h0005, 1'b0, 1'b1, acc_a);
        wait_valid();
        check("sub_pos_sum", 32'(out_sum), 32'h0002);
        check("sub_pos_cout", 32'(out_cout), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Random traffic with random consumer backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic s;
`ifdef NSA_SUB_EN
                    s = 1'($urandom % 2);
`else
                    s = 1'b0;
`endif
                    repeat ($urandom % 3) begin
                        @(posedge clk);
                        #1;
                    end
                    send(W'($urandom), W'($urandom), 1'($urandom % 2), s, acc_a);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom % 4) != 0;
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
